mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: B, default 32, data/address width; W, default 10, data_mem word-address width.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Clock and reset ports SHALL be: i_clk, input, 1, rising-edge clock; i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 Request ports SHALL be:
- i_valid, input, 1: request present.
- o_ready, output, 1: unit idle, can accept.
- i_mem_read, input, 1: load request.
- i_mem_write, input, 1: store request.
- i_size, input, 2: 00 byte, 01 half, 10/11 word.
- i_unsigned, input, 1: zero-extend loads.
REQ-005 Address and data ports SHALL be:
- i_addr, input, B: byte address (ALU result).
- i_wdata, input, B: store data.
- o_rdata, output, B: extended load result.
- o_rvalid, output, 1: load-result pulse.
- o_misaligned, output, 1: alignment-error pulse.
- o_stall, output, 1: busy flag for the hazard unit.
REQ-006 data_mem-side ports SHALL be:
- o_dm_read, output, 1.
- o_dm_write, output, 1.
- o_dm_addr, output, W.
- o_dm_wdata, output, B.
- i_dm_rdata, input, B: valid one cycle after o_dm_read is sampled.

Function
REQ-007 Handshake SHALL be: accept on rising edge with i_valid&&o_ready&&(i_mem_read||i_mem_write); o_ready = (state==IDLE); o_stall = !o_ready.
REQ-008 i_mem_write SHALL take priority when both i_mem_read and i_mem_write are high; the read is dropped.
REQ-009 o_dm_addr SHALL be i_addr[W+1:2], registered at accept; bits above W+1 are ignored, so addresses wrap modulo 2^(W+2) bytes.
REQ-010 Alignment SHALL be checked as follows:
- half with addr[0]=1, or word with addr[1:0]!=0, is misaligned;
- o_misaligned pulses for one cycle, the cycle after accept;
- no data_mem strobe is issued and the state stays IDLE.
REQ-011 Byte lanes SHALL be little-endian: byte k=addr[1:0] is bits [8k+7:8k]; half h=addr[1] is bits [16h+15:16h].
REQ-012 The FSM states SHALL be IDLE, RD, MERGE, WR, LDRET.
REQ-013 A word store SHALL go IDLE -> WR -> IDLE, with o_dm_write=1 and o_dm_wdata=i_wdata for one cycle in WR.
REQ-014 A sub-word store SHALL go IDLE -> RD -> MERGE -> WR -> IDLE:
- RD asserts o_dm_read;
- MERGE captures i_dm_rdata and replaces only the addressed lane with i_wdata's low byte or half;
- WR writes the merged word.
REQ-015 A load SHALL go IDLE -> RD -> LDRET -> IDLE.
REQ-016 In LDRET, o_rdata SHALL be the selected lane sign- or zero-extended per i_unsigned, with o_rvalid=1 for exactly one cycle.
REQ-017 Load latency SHALL be 2 cycles after accept; word store takes 1 cycle; sub-word store takes 3 cycles.
REQ-018 o_dm_read and o_dm_write SHALL never be high in the same cycle; each SHALL be high only in RD and WR respectively.
REQ-019 o_rdata SHALL hold its last value outside LDRET; o_dm_wdata and o_dm_addr SHALL hold between operations.
REQ-020 Requests presented while o_ready=0 SHALL be ignored; upstream must hold them.

Reset
REQ-021 While i_rst_n=0, the state SHALL be IDLE immediately (asynchronous).
REQ-022 While i_rst_n=0: o_ready=1; o_stall, o_rvalid, o_misaligned, o_dm_read, o_dm_write=0; o_rdata, o_dm_addr, o_dm_wdata=0.
REQ-023 Reset asserted in RD, MERGE or WR SHALL abort the operation with no partial write; an aborted load SHALL produce no o_rvalid.

Structure
REQ-024 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings SHALL live in the shared MEM-stage package/include, shared with the EX/MEM register and control unit.
REQ-025 Lane select plus sign/zero extension SHALL be one combinational sub-module, load_extend, reused by MERGE lane logic where natural.
REQ-026 The unit SHALL instantiate no memory; it connects to data_mem (B=32, W=10) at the MEM-stage top.

Verification
REQ-027 Word store, then load: store 0xDEADBEEF at addr 0x010, then load word at 0x010 -> o_rvalid 2 cycles after accept, o_rdata=0xDEADBEEF, o_dm_addr=4.
REQ-028 Byte store and loads: word 0x11223344 at 0x020, store byte 0xA5 at 0x022 -> memory 0x11A53344; signed byte load at 0x022 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-029 Half loads: half load at 0x022 from 0x8001BEEF, signed -> 0xFFFF8001; unsigned -> 0x00008001.
REQ-030 Misaligned access: word load at 0x013 -> o_misaligned pulse, no o_dm_read or o_dm_write, o_ready stays 1.
REQ-031 Reset mid-store: i_rst_n low during MERGE of a byte store to 0x030 holding 0x0 -> memory stays 0x0, state IDLE, o_dm_write never high.
REQ-032 Back-to-back and wrap: requests held while o_stall=1 are accepted only when o_ready=1; store to 0x1004 with W=10 lands at o_dm_addr=1.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - MEM-stage shared size/state encodings and alignment helper
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_MERGE = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_LDRET = 3'd4;

    typedef struct packed {
        logic       is_write;
        logic [1:0] size;
        logic       is_unsigned;
        logic [1:0] lane;
    } op_t;

    // Size 2'b11 is treated as a word, so any size with bit 1 set needs full alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        if ((size & SZ_WORD) != 2'b00)
            return lane != 2'b00;
        else if (size == SZ_HALF)
            return lane[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - little-endian lane select with sign/zero extension
module load_extend
    import mem_access_unit_pkg::*;
#(
    parameter int B = 32
) (
    input  logic [B-1:0] word,
    input  logic [1:0]   lane,
    input  logic [1:0]   size,
    input  logic         is_unsigned,
    output logic [B-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];

        ext = word;
        if (size == SZ_BYTE)
            ext = {{(B-8){~is_unsigned & byte_sel[7]}}, byte_sel};
        else if (size == SZ_HALF)
            ext = {{(B-16){~is_unsigned & half_sel[15]}}, half_sel};
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store sequencer with sub-word read-modify-write
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int B = 32,
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic [1:0]   i_size,
    input  logic         i_unsigned,
    input  logic [B-1:0] i_addr,
    input  logic [B-1:0] i_wdata,
    output logic [B-1:0] o_rdata,
    output logic         o_rvalid,
    output logic         o_misaligned,
    output logic         o_stall,
    output logic         o_dm_read,
    output logic         o_dm_write,
    output logic [W-1:0] o_dm_addr,
    output logic [B-1:0] o_dm_wdata,
    input  logic [B-1:0] i_dm_rdata
);

    logic [2:0]   state;
    op_t          op_q;
    logic [15:0]  wlo_q;
    logic [W-1:0] dm_addr_q;
    logic [B-1:0] dm_wdata_q;
    logic [B-1:0] rdata_q;
    logic         mis_q;

    logic         accept;
    logic         acc_mis;
    logic [B-1:0] ld_ext;
    logic [B-1:0] merged;
    logic         unused_addr_hi;

    // Address bits above the data_mem window are dropped so accesses wrap.
    assign unused_addr_hi = ^i_addr[B-1:W+2];

    assign accept  = i_valid && (state == ST_IDLE) && (i_mem_read || i_mem_write);
    assign acc_mis = is_misaligned(i_size, i_addr[1:0]);

    load_extend #(.B(B)) u_load_extend (
        .word        (i_dm_rdata),
        .lane        (op_q.lane),
        .size        (op_q.size),
        .is_unsigned (op_q.is_unsigned),
        .ext         (ld_ext)
    );

    always_comb begin
        merged = i_dm_rdata;
        if (op_q.size == SZ_BYTE) begin
            case (op_q.lane)
                2'd0: merged[7:0]   = wlo_q[7:0];
                2'd1: merged[15:8]  = wlo_q[7:0];
                2'd2: merged[23:16] = wlo_q[7:0];
                2'd3: merged[31:24] = wlo_q[7:0];
                default: merged = i_dm_rdata;
            endcase
        end else if (op_q.size == SZ_HALF) begin
            if (op_q.lane[1])
                merged[31:16] = wlo_q;
            else
                merged[15:0] = wlo_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            wlo_q      <= '0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            rdata_q    <= '0;
            mis_q      <= 1'b0;
        end else begin
            mis_q <= accept && acc_mis;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dm_addr_q        <= i_addr[W+1:2];
                        op_q.is_write    <= i_mem_write;
                        op_q.size        <= i_size;
                        op_q.is_unsigned <= i_unsigned;
                        op_q.lane        <= i_addr[1:0];
                        wlo_q            <= i_wdata[15:0];
                        if (!acc_mis) begin
                            // Full-word stores skip the read-modify-write path.
                            if (i_mem_write && i_size[1]) begin
                                dm_wdata_q <= i_wdata;
                                state      <= ST_WR;
                            end else begin
                                state <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD:    state <= op_q.is_write ? ST_MERGE : ST_LDRET;
                ST_MERGE: begin
                    dm_wdata_q <= merged;
                    state      <= ST_WR;
                end
                ST_WR:    state <= ST_IDLE;
                ST_LDRET: begin
                    rdata_q <= ld_ext;
                    state   <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready      = (state == ST_IDLE);
    assign o_stall      = !o_ready;
    assign o_dm_read    = (state == ST_RD);
    assign o_dm_write   = (state == ST_WR);
    assign o_dm_addr    = dm_addr_q;
    assign o_dm_wdata   = dm_wdata_q;
    assign o_rvalid     = (state == ST_LDRET);
    assign o_rdata      = (state == ST_LDRET) ? ld_ext : rdata_q;
    assign o_misaligned = mis_q;

endmodule
